// File: rtl/pc_fetch_ctrl.sv
// Purpose : IF-stage PC generator; drives an instruction-memory req/gnt port,
//           applies flush / branch / stall and parks redirects behind an un-granted request.
// Latency : sequential PC advances 1 cycle after grant; a direct redirect lands 1 cycle later;
//           a parked redirect lands in the cycle after the grant.
// Backpr. : if_gnt low holds pc/if_addr and keeps if_req high; stall[0] blocks new requests only.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   stall             ctrl stall bus, only stall[0] is used (freezes fetch)
//   flush, new_pc     pipeline flush and its target (sampled every cycle)
//   branch_flag_i/_tgt_i  taken branch from ID (sampled only when not stalled)
//   if_gnt            memory accepts the current request
//   ce                fetch enable (low for one cycle after reset)
//   pc, if_addr       current fetch PC; if_addr is always pc
//   if_req            fetch request, combinational
//   misalign_o/_addr  misaligned-redirect pulse and the raw offending target
//
// Optional feature: define PC_ALIGN_CHECK_EN to trap misaligned redirect targets to
// EXC_VEC (with misalign_o/misalign_addr); otherwise the low target bits are cleared
// and the misalign outputs are tied to zero.

module pc_fetch_ctrl #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RST_VEC    = '0,
  parameter int                INST_BYTES = 4,
  parameter int                STALL_W    = 6,
  parameter logic [ADDR_W-1:0] EXC_VEC    = 'h20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_tgt_i,
  input  logic               if_gnt,
  output logic               ce,
  output logic [ADDR_W-1:0]  pc,
  output logic               if_req,
  output logic [ADDR_W-1:0]  if_addr,
  output logic               misalign_o,
  output logic [ADDR_W-1:0]  misalign_addr
);

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_BYTES);
  // INST_BYTES is a power of two, so INST_BYTES-1 masks exactly the sub-instruction bits.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);

  logic              wait_q;      // request issued and not yet granted
  logic              pend_vld;    // a redirect is parked behind the outstanding request
  logic              pend_flush;  // the parked redirect came from a flush
  logic [ADDR_W-1:0] pend_addr;   // raw (unaligned) parked target

  logic              hs;          // handshake this cycle
  logic              blocked;     // request presented but not granted
  logic              br_vld;
  logic              redir_vld;
  logic [ADDR_W-1:0] redir_raw;
  logic              take_pend;
  logic              apply_vld;
  logic [ADDR_W-1:0] apply_raw;
  logic [ADDR_W-1:0] apply_tgt;
  logic [ADDR_W-1:0] pc_seq;
  logic              unused_stall;

  assign unused_stall = ^stall;

  assign if_req    = ce & (wait_q | ~stall[0]);
  assign if_addr   = pc;
  assign hs        = if_req & if_gnt;
  assign blocked   = if_req & ~if_gnt;
  assign br_vld    = branch_flag_i & ~stall[0];
  assign redir_vld = flush | br_vld;
  // Flush outranks a same-cycle branch; the branch is simply dropped.
  assign redir_raw = flush ? new_pc : branch_tgt_i;
  assign pc_seq    = pc + STEP;

  // At the grant, a parked flush still beats a branch arriving in the same cycle, so a
  // flush is never lost; otherwise the newest redirect wins.
  assign take_pend = pend_vld & (~redir_vld | (pend_flush & ~flush));

  always_comb begin
    apply_vld = 1'b0;
    apply_raw = redir_raw;
    if (hs) begin
      if (take_pend) begin
        apply_vld = 1'b1;
        apply_raw = pend_addr;
      end else if (redir_vld) begin
        apply_vld = 1'b1;
      end
    end else if (ce && !if_req && redir_vld) begin
      // Nothing outstanding: the redirect (a flush while stalled) loads pc directly.
      apply_vld = 1'b1;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic apply_mis;
  assign apply_mis = |(apply_raw & ALIGN_MASK);
  assign apply_tgt = apply_mis ? EXC_VEC : apply_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_o    <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign_o <= apply_vld & apply_mis;
      if (apply_vld && apply_mis) begin
        misalign_addr <= apply_raw;
      end
    end
  end
`else
  assign apply_tgt     = apply_raw & ~ALIGN_MASK;
  assign misalign_o    = 1'b0;
  assign misalign_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ce         <= 1'b0;
      pc         <= RST_VEC;
      wait_q     <= 1'b0;
      pend_vld   <= 1'b0;
      pend_flush <= 1'b0;
      pend_addr  <= '0;
    end else begin
      ce     <= 1'b1;
      wait_q <= blocked;

      // Hold rule: pc only moves on a grant or when no request is outstanding.
      if (!ce) begin
        pc <= RST_VEC;
      end else if (apply_vld) begin
        pc <= apply_tgt;
      end else if (hs) begin
        pc <= pc_seq;
      end

      if (hs) begin
        pend_vld   <= 1'b0;
        pend_flush <= 1'b0;
      end else if (blocked && redir_vld && !(pend_vld && pend_flush && !flush)) begin
        pend_vld   <= 1'b1;
        pend_flush <= flush;
        pend_addr  <= redir_raw;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_tgt_i;
  logic        if_gnt;
  logic        ce;
  logic [31:0] pc;
  logic        if_req;
  logic [31:0] if_addr;
  logic        misalign_o;
  logic [31:0] misalign_addr;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [31:0] EXP_MIS_PC   = 32'h20;
  localparam logic [31:0] EXP_MIS_O    = 32'd1;
  localparam logic [31:0] EXP_MIS_ADDR = 32'h102;
`else
  localparam logic [31:0] EXP_MIS_PC   = 32'h100;
  localparam logic [31:0] EXP_MIS_O    = 32'd0;
  localparam logic [31:0] EXP_MIS_ADDR = 32'h0;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  pc_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag_i (branch_flag_i),
    .branch_tgt_i  (branch_tgt_i),
    .if_gnt        (if_gnt),
    .ce            (ce),
    .pc            (pc),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .misalign_o    (misalign_o),
    .misalign_addr (misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted fetch must match the next expected address.
  always @(negedge clk) begin
    if (!rst && if_req === 1'b1 && if_gnt === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_fetch", if_addr, 32'hDEADBEEF);
      end else begin
        chk("fetch_addr", if_addr, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0;
    branch_flag_i = 1'b0; branch_tgt_i = '0; if_gnt = 1'b0;

    // Reset
    step(); step();
    chk("rst_ce", {31'd0, ce}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_req", {31'd0, if_req}, 32'd0);
    chk("rst_mis_o", {31'd0, misalign_o}, 32'd0);
    chk("rst_mis_addr", misalign_addr, 32'd0);
    rst = 1'b0;
    #1 chk("ce_after_release", {31'd0, ce}, 32'd0);
    step();
    chk("ce_on", {31'd0, ce}, 32'd1);
    chk("pc_start", pc, 32'd0);
    chk("req_on", {31'd0, if_req}, 32'd1);

    // Sequential fetch with gnt tied high
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    if_gnt = 1'b1;
    repeat (4) step();
    if_gnt = 1'b0;
    chk("pc_seq_end", pc, 32'h10);

    // Branch during an un-granted request: address held, lands after grant
    branch_flag_i = 1'b1; branch_tgt_i = 32'h100;
    step(); branch_flag_i = 1'b0;
    chk("hold1", if_addr, 32'h10);
    step(); chk("hold2", if_addr, 32'h10);
    step(); chk("hold3", if_addr, 32'h10);
    exp_q.push_back(32'h10); exp_q.push_back(32'h100);
    if_gnt = 1'b1;
    step(); step();
    if_gnt = 1'b0;

    // Parked branch, then flush overwrites it
    branch_flag_i = 1'b1; branch_tgt_i = 32'h100;
    step(); branch_flag_i = 1'b0;
    flush = 1'b1; new_pc = 32'h200;
    step(); flush = 1'b0;
    chk("hold_pend", pc, 32'h104);
    exp_q.push_back(32'h104); exp_q.push_back(32'h200);
    if_gnt = 1'b1;
    step(); step();
    if_gnt = 1'b0;

    // Parked flush, later branch must not replace it
    flush = 1'b1; new_pc = 32'h200;
    step(); flush = 1'b0;
    branch_flag_i = 1'b1; branch_tgt_i = 32'h100;
    step(); branch_flag_i = 1'b0;
    exp_q.push_back(32'h204); exp_q.push_back(32'h200);
    if_gnt = 1'b1;
    step(); step();

    // Branch at the grant to the top of memory, then wrap to 0
    branch_flag_i = 1'b1; branch_tgt_i = 32'hFFFF_FFFC;
    exp_q.push_back(32'h204);
    step(); branch_flag_i = 1'b0;
    chk("pc_top", pc, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    step();
    chk("pc_wrap", pc, 32'h0);
    step();

    // Stall with nothing outstanding: no request, branch ignored, flush still applies
    if_gnt = 1'b0; stall = 6'b000001;
    branch_flag_i = 1'b1; branch_tgt_i = 32'h300;
    #1 chk("stall_req", {31'd0, if_req}, 32'd0);
    step(); branch_flag_i = 1'b0;
    chk("stall_pc_hold", pc, 32'h4);
    flush = 1'b1; new_pc = 32'h40;
    step(); flush = 1'b0;
    chk("stall_flush_pc", pc, 32'h40);
    chk("stall_flush_req", {31'd0, if_req}, 32'd0);
    stall = '0;
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    if_gnt = 1'b1;
    step(); step();
    if_gnt = 1'b0;

    // Stall rising after a request is issued must not withdraw it
    step();
    stall = 6'b000001;
    #1 chk("req_kept", {31'd0, if_req}, 32'd1);
    chk("req_kept_pc", pc, 32'h48);
    exp_q.push_back(32'h48);
    if_gnt = 1'b1;
    step(); if_gnt = 1'b0;
    chk("req_drop", {31'd0, if_req}, 32'd0);
    chk("req_drop_pc", pc, 32'h4C);
    stall = '0;

    // Misaligned branch target parked behind a request
    branch_flag_i = 1'b1; branch_tgt_i = 32'h102;
    step(); branch_flag_i = 1'b0;
    exp_q.push_back(32'h4C); exp_q.push_back(EXP_MIS_PC);
    if_gnt = 1'b1;
    step();
    chk("mis_pc", pc, EXP_MIS_PC);
    chk("mis_o", {31'd0, misalign_o}, EXP_MIS_O);
    chk("mis_addr", misalign_addr, EXP_MIS_ADDR);
    step();
    chk("mis_o_clear", {31'd0, misalign_o}, 32'd0);
    chk("mis_addr_held", misalign_addr, EXP_MIS_ADDR);
    if_gnt = 1'b0;

    // Reset with a request outstanding and a redirect parked
    branch_flag_i = 1'b1; branch_tgt_i = 32'h500;
    step(); branch_flag_i = 1'b0;
    rst = 1'b1;
    step();
    chk("mid_rst_ce", {31'd0, ce}, 32'd0);
    chk("mid_rst_pc", pc, 32'd0);
    chk("mid_rst_req", {31'd0, if_req}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_pc", pc, 32'd0);

    // Simultaneous flush and branch at a grant: flush wins, parked 0x500 is gone
    flush = 1'b1; new_pc = 32'h80;
    branch_flag_i = 1'b1; branch_tgt_i = 32'h300;
    exp_q.push_back(32'h0); exp_q.push_back(32'h80); exp_q.push_back(32'h84);
    if_gnt = 1'b1;
    step();
    flush = 1'b0; branch_flag_i = 1'b0;
    chk("flush_wins_pc", pc, 32'h80);
    step(); step();
    if_gnt = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
